alu_issue_ctrl: RTL and testbench

Initiator side of the ALU operand protocol. It accepts ALU operation requests over a valid/ready interface and buffers them in a small FIFO. Each request is issued to the ALU as one combined beat or as two split beats with a programmable gap. After a fixed latency it captures RES and the flags and returns them over a valid/ready response interface. Only one operation is in flight at a time. It sits between the test/sequencer fabric and the ALU.

---
 rtl/alu_issue_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers ALU requests, issues them as combined or split beats, and returns the captured result
module alu_issue_ctrl #(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int DEPTH   = 4,
    parameter int LAT     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_opa,
    input  logic [DW-1:0] req_opb,
    input  logic [CW-1:0] req_cmd,
    input  logic          req_mode,
    input  logic          req_cin,
    input  logic [1:0]    req_split,
    input  logic [4:0]    req_gap,
    output logic [1:0]    inp_valid,
    output logic [DW-1:0] opa,
    output logic [DW-1:0] opb,
    output logic [CW-1:0] cmd,
    output logic          mode,
    output logic          cin,
    output logic          ce,
    input  logic [DW+1:0] res,
    input  logic          cout,
    input  logic          oflow,
    input  logic          g,
    input  logic          e,
    input  logic          l,
    input  logic          err,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW+1:0] rsp_res,
    output logic [5:0]    rsp_flags,
    output logic          rsp_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * DW + CW + 9;

    typedef enum logic [2:0] {IDLE, BEAT1, GAP, BEAT2, WAIT, RESP} state_t;

    state_t        state, nxt;
    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wp, rp, used_n;
    logic          push, pop, empty, nxt_ce;
    logic [EW-1:0] head;
    logic [DW-1:0] h_opa, h_opb;
    logic [CW-1:0] h_cmd;
    logic          h_mode, h_cin;
    logic [1:0]    h_split, cur_split, sp, nxt_iv;
    logic [4:0]    h_gap, cur_gap, cnt;

    assign push   = req_valid && req_ready;
    assign empty  = wp == rp;
    assign pop    = state == IDLE && !empty;
    assign used_n = wp - rp + (AW+1)'(push) - (AW+1)'(pop);
    assign head   = mem[rp[AW-1:0]];
    assign {h_opa, h_opb, h_cmd, h_mode, h_cin, h_split, h_gap} = head;
    // split mode of the op being issued: the FIFO head while still popping it
    assign sp     = state == IDLE ? h_split : cur_split;
    assign nxt_iv = nxt == BEAT1 ? (sp == 2'b01 ? 2'b01 : sp == 2'b10 ? 2'b10 : 2'b11) :
                    nxt == BEAT2 ? (sp == 2'b01 ? 2'b10 : 2'b01) : 2'b00;
    assign nxt_ce = nxt inside {BEAT1, GAP, BEAT2, WAIT};

    // request storage; split code 11 is folded to combined on entry, pointers qualify contents
    always_ff @(posedge clk)
        if (push) mem[wp[AW-1:0]] <= {req_opa, req_opb, req_cmd, req_mode, req_cin,
                                      (req_split == 2'b11 ? 2'b00 : req_split), req_gap};

    // FIFO pointers; ready looks ahead at this edge's push/pop so it never overflows
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp        <= '0;
            rp        <= '0;
            req_ready <= 1'b0;
        end else begin
            wp        <= wp + (AW+1)'(push);
            rp        <= rp + (AW+1)'(pop);
            req_ready <= used_n != (AW+1)'(DEPTH);
        end

    // state register and a shared cycle counter that restarts on every state change
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= nxt != state ? 5'd0 : cnt + 5'd1;
        end

    // next-state: gap cycles counted in GAP, LAT edges counted in WAIT
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = empty ? IDLE : BEAT1;
            BEAT1:   nxt = sp == 2'b00 ? WAIT : cur_gap != 5'd0 ? GAP : BEAT2;
            GAP:     nxt = cnt == cur_gap - 5'd1 ? BEAT2 : GAP;
            BEAT2:   nxt = WAIT;
            WAIT:    nxt = cnt == 5'(LAT - 1) ? RESP : WAIT;
            RESP:    nxt = rsp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    // registered ALU drive, operand load on pop, and response capture/handshake
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            inp_valid   <= 2'b00;
            ce          <= 1'b0;
            opa         <= '0;
            opb         <= '0;
            cmd         <= '0;
            mode        <= 1'b0;
            cin         <= 1'b0;
            cur_split   <= 2'b00;
            cur_gap     <= 5'd0;
            rsp_valid   <= 1'b0;
            rsp_res     <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            inp_valid <= nxt_iv;
            ce        <= nxt_ce;
            if (pop) begin
                opa       <= h_opa;
                opb       <= h_opb;
                cmd       <= h_cmd;
                mode      <= h_mode;
                cin       <= h_cin;
                cur_split <= h_split;
                cur_gap   <= h_gap;
            end
            if (state == WAIT && nxt == RESP) begin
                rsp_valid   <= 1'b1;
                rsp_res     <= res;
                rsp_flags   <= {cout === 1'b1, oflow === 1'b1, g === 1'b1,
                                e === 1'b1, l === 1'b1, err === 1'b1};
                rsp_timeout <= cur_split != 2'b00 && 32'(cur_gap) >= TIMEOUT;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: vector table plus scoreboard against a small ALU model with fixed result latency
module tb_alu_issue_ctrl;
    localparam int LAT = 2;
    localparam logic [15:0] JUNK = 16'hAAAA;

    typedef struct {
        logic [7:0] opa, opb;
        logic [3:0] cmd;
        logic       mode;
        logic [1:0] split;
        logic [4:0] gap;
        logic [9:0] eres;
        logic [5:0] eflg;
        logic       eto;
    } vec_t;

    typedef struct {
        logic [9:0] res;
        logic [5:0] flg;
        logic       to;
    } exp_t;

    logic       clk, rst_n, req_valid, req_ready, req_mode, req_cin;
    logic [7:0] req_opa, req_opb, opa, opb;
    logic [3:0] req_cmd, cmd;
    logic [1:0] req_split, inp_valid;
    logic [4:0] req_gap;
    logic       mode, cin, ce, cout, oflow, g, e, l, err;
    logic [9:0] res, rsp_res, held;
    logic       rsp_valid, rsp_ready, rsp_timeout;
    logic [5:0] rsp_flags;
    int         total, bad;
    exp_t       q[$];
    exp_t       sbx;
    vec_t       vt[9];
    logic       pend;
    logic [15:0] dl [LAT];

    alu_issue_ctrl #(.DW(8), .CW(4), .DEPTH(4), .LAT(LAT), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd), .req_mode(req_mode),
        .req_cin(req_cin), .req_split(req_split), .req_gap(req_gap),
        .inp_valid(inp_valid), .opa(opa), .opb(opb), .cmd(cmd), .mode(mode), .cin(cin),
        .ce(ce), .res(res), .cout(cout), .oflow(oflow), .g(g), .e(e), .l(l), .err(err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
        .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, x);
        end
    endtask

    // reference ALU: returns {res[9:0], cout, oflow, g, e, l, err}
    function automatic logic [15:0] alu(input logic m, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [9:0] r;
        logic [5:0] f;
        r = '0;
        f = '0;
        if (m && c == 4'd0) begin
            r = 10'(a) + 10'(b);
            f[5] = r[8];
        end else if (m && c == 4'd1) begin
            r = 10'(a) - 10'(b);
            f[4] = a < b;
        end else if (m && c == 4'd8) begin
            f[3] = a > b;
            f[2] = a == b;
            f[1] = a < b;
        end else if (!m && c == 4'd0) begin
            r = {2'b00, a & b};
        end else begin
            f[0] = 1'b1;
        end
        return {r, f};
    endfunction

    // ALU model: result valid only on the cycle LAT edges after the final operand beat
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pend <= 1'b0;
            for (int i = 0; i < LAT; i++) dl[i] <= JUNK;
        end else begin
            if (ce && inp_valid != 2'b00) pend <= inp_valid != 2'b11 && !pend;
            dl[0] <= (ce && (inp_valid == 2'b11 || (inp_valid != 2'b00 && pend))) ? alu(mode, cmd, opa, opb) : JUNK;
            for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
        end
    assign {res, cout, oflow, g, e, l, err} = dl[LAT-1];

    // scoreboard: compare each accepted response against the oldest expectation
    always @(negedge clk)
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) chk("sb_expected_present", 32'(q.size() != 0), 32'd1);
            else begin
                sbx = q.pop_front();
                chk("sb_res", 32'(rsp_res), 32'(sbx.res));
                chk("sb_flags", 32'(rsp_flags), 32'(sbx.flg));
                chk("sb_timeout", 32'(rsp_timeout), 32'(sbx.to));
            end
        end

    task automatic send(input vec_t v);
        logic ok;
        exp_t x;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_opa   = v.opa;
        req_opb   = v.opb;
        req_cmd   = v.cmd;
        req_mode  = v.mode;
        req_cin   = 1'b0;
        req_split = v.split;
        req_gap   = v.gap;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_ready_wait", 32'(ok), 32'd1);
        @(posedge clk);
        x.res = v.eres;
        x.flg = v.eflg;
        x.to  = v.eto;
        q.push_back(x);
        #1 req_valid = 1'b0;
    endtask

    task automatic run(input vec_t v, input int idx);
        logic [1:0] sp, first, last, ef, el;
        int nb, nc, lat, enc;
        send(v);
        sp = v.split == 2'b11 ? 2'b00 : v.split;
        first = 2'b00;
        last = 2'b00;
        nb = 0;
        nc = 0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k - 1;
                break;
            end
            if (ce) nc++;
            if (inp_valid != 2'b00) begin
                if (nb == 0) first = inp_valid;
                last = inp_valid;
                nb++;
            end
        end
        ef  = sp == 2'b01 ? 2'b01 : sp == 2'b10 ? 2'b10 : 2'b11;
        el  = sp == 2'b01 ? 2'b10 : sp == 2'b10 ? 2'b01 : 2'b11;
        enc = 1 + LAT + (sp != 2'b00 ? int'(v.gap) + 1 : 0);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(enc + 1));
        chk($sformatf("v%0d_ce_cycles", idx), 32'(nc), 32'(enc));
        chk($sformatf("v%0d_beats", idx), 32'(nb), sp != 2'b00 ? 32'd2 : 32'd1);
        chk($sformatf("v%0d_first_beat", idx), 32'(first), 32'(ef));
        chk($sformatf("v%0d_last_beat", idx), 32'(last), 32'(el));
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n;
        logic r, seen, found;
        exp_t x;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_opa = '0;
        req_opb = '0;
        req_cmd = '0;
        req_mode = 1'b0;
        req_cin = 1'b0;
        req_split = '0;
        req_gap = '0;
        rsp_ready = 1'b1;
        vt[0] = '{8'd200, 8'd100, 4'd0, 1'b1, 2'd0, 5'd0,  10'h12C, 6'b100000, 1'b0};
        vt[1] = '{8'd50,  8'd70,  4'd1, 1'b1, 2'd1, 5'd3,  10'h3EC, 6'b010000, 1'b0};
        vt[2] = '{8'd5,   8'd5,   4'd8, 1'b1, 2'd2, 5'd0,  10'h000, 6'b000100, 1'b0};
        vt[3] = '{8'hF0,  8'h3C,  4'd0, 1'b0, 2'd1, 5'd20, 10'h030, 6'b000000, 1'b1};
        vt[4] = '{8'd1,   8'd2,   4'd0, 1'b1, 2'd3, 5'd9,  10'h003, 6'b000000, 1'b0};
        vt[5] = '{8'd9,   8'd3,   4'd8, 1'b1, 2'd2, 5'd16, 10'h000, 6'b001000, 1'b1};
        vt[6] = '{8'd255, 8'd255, 4'd0, 1'b1, 2'd1, 5'd15, 10'h1FE, 6'b100000, 1'b0};
        vt[7] = '{8'd7,   8'd7,   4'hF, 1'b0, 2'd0, 5'd0,  10'h000, 6'b000001, 1'b0};
        vt[8] = '{8'hAA,  8'h0F,  4'd0, 1'b0, 2'd1, 5'd31, 10'h00A, 6'b000000, 1'b1};

        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_inp_valid", 32'(inp_valid), 32'd0);
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_ops", {opa, opb, cmd, mode, cin, 6'd0}, 32'd0);
        chk("rst_rsp", {rsp_valid, rsp_res, rsp_flags, rsp_timeout}, 32'd0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_edge", 32'(req_ready), 32'd1);

        for (int i = 0; i < 9; i++) run(vt[i], i);

        // backpressure: responses stalled, requests pushed continuously from reset
        @(negedge clk);
        #2 rst_n = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_opa = 8'd1;
        req_opb = 8'd1;
        req_cmd = 4'd0;
        req_mode = 1'b1;
        req_split = 2'd0;
        req_gap = 5'd0;
        #2 rst_n = 1'b1;
        acc = 0;
        seen = 1'b0;
        held = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r = req_ready;
            if (rsp_valid && !seen) begin
                seen = 1'b1;
                held = rsp_res;
            end
            @(posedge clk);
            if (r) begin
                acc++;
                x.res = 10'(acc + 1);
                x.flg = 6'b000000;
                x.to = 1'b0;
                q.push_back(x);
            end
            #1 req_opa = 8'(acc + 1);
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepted", 32'(acc), 32'd5);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_res_stable", 32'(rsp_res), 32'(held));
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (inp_valid == 2'b11) begin
                found = 1'b1;
                break;
            end
        end
        chk("bp_next_op_start", 32'(found), 32'd1);
        chk("bp_ready_reopen", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
        chk("bp_drained", 32'(q.size()), 32'd0);

        // reset asserted while the controller sits in the gap between split beats
        send('{8'h10, 8'h20, 4'd0, 1'b1, 2'd1, 5'd10, 10'h030, 6'b000000, 1'b0});
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (inp_valid == 2'b01) begin
                found = 1'b1;
                break;
            end
        end
        chk("gap_first_beat_seen", 32'(found), 32'd1);
        @(negedge clk);
        chk("gap_ce", 32'(ce), 32'd1);
        chk("gap_inp_valid", 32'(inp_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_inp_valid", 32'(inp_valid), 32'd0);
        chk("async_rst_ce", 32'(ce), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ce || rsp_valid || inp_valid != 2'b00) n++;
        end
        chk("post_rst_idle", 32'(n), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        run('{8'd9, 8'd4, 4'd1, 1'b1, 2'd0, 5'd0, 10'h005, 6'b000000, 1'b0}, 9);
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
